cache_refill_ctrl: RTL and testbench

- Memory-side responder for the 4-set, direct-mapped, 4-word-line data cache.
- On a cache miss it fetches the whole 16-byte line from main memory, one word per memory transaction.
- It then presents the line as d0..d3 with a single-cycle refill_valid strobe, which the cache uses to fill its line.
- It sits between the cache's miss output and the main-memory read port.

---
 rtl/cache_refill_ctrl.sv | 135 +++++++++++++
 tb/tb_cache_refill_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// Memory-side refill engine for the direct-mapped data cache: fetches a 4-word
// line one beat at a time and returns it with a one-cycle valid (or error) strobe.
module cache_refill_ctrl #(
   parameter int DATA_WIDTH     = 32,
   parameter int WORDS_PER_LINE = 4,
   parameter int TIMEOUT        = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  miss_req,
   input  logic [DATA_WIDTH-1:0] miss_addr,
   output logic                  busy,
   output logic                  refill_valid,
   output logic                  refill_err,
   output logic [DATA_WIDTH-7:0] refill_tag,
   output logic [DATA_WIDTH-1:0] d0,
   output logic [DATA_WIDTH-1:0] d1,
   output logic [DATA_WIDTH-1:0] d2,
   output logic [DATA_WIDTH-1:0] d3,
   output logic                  mem_req,
   output logic [DATA_WIDTH-1:0] mem_addr,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int                WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [1:0]        LAST_BEAT = 2'(WORDS_PER_LINE - 1);

   typedef enum logic [1:0] {IDLE, FETCH, RESP, ERR} state_t;

   state_t                  state_q, state_d;
   logic [1:0]              beat_q, beat_d;
   logic [WAIT_W-1:0]       wait_q, wait_d;
   logic [DATA_WIDTH-7:0]   tag_q, tag_d;
   logic [DATA_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic                    mem_req_q, mem_req_d;
   logic                    busy_q, busy_d;
   logic                    valid_q, valid_d;
   logic                    err_q, err_d;
   logic                    capture;
   logic [DATA_WIDTH-1:0]   word_q [WORDS_PER_LINE];
   logic                    unused_offset_bits;

   // Line base is word-aligned to 16 bytes, so the low offset bits never matter.
   assign unused_offset_bits = ^miss_addr[3:0];

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      wait_d     = wait_q;
      tag_d      = tag_q;
      mem_addr_d = mem_addr_q;
      mem_req_d  = 1'b0;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      capture    = 1'b0;
      case (state_q)
         IDLE: begin
            if (miss_req) begin
               state_d    = FETCH;
               tag_d      = miss_addr[DATA_WIDTH-1:6];
               mem_addr_d = {miss_addr[DATA_WIDTH-1:4], 4'b0000};
               beat_d     = 2'd0;
               wait_d     = '0;
               mem_req_d  = 1'b1;
            end
         end
         FETCH: begin
            mem_req_d = 1'b1;
            if (mem_rvalid) begin
               capture = 1'b1;
               wait_d  = '0;
               if (beat_q == LAST_BEAT) begin
                  state_d   = RESP;
                  mem_req_d = 1'b0;
                  valid_d   = 1'b1;
               end else begin
                  beat_d     = beat_q + 2'd1;
                  mem_addr_d = mem_addr_q + DATA_WIDTH'(4);
               end
            end else if ((TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
               state_d   = ERR;
               mem_req_d = 1'b0;
               err_d     = 1'b1;
               wait_d    = '0;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         RESP:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         beat_q     <= '0;
         wait_q     <= '0;
         tag_q      <= '0;
         mem_addr_q <= '0;
         mem_req_q  <= 1'b0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         for (int i = 0; i < WORDS_PER_LINE; i++) word_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         wait_q     <= wait_d;
         tag_q      <= tag_d;
         mem_addr_q <= mem_addr_d;
         mem_req_q  <= mem_req_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         if (capture) word_q[beat_q] <= mem_rdata;
      end
   end

   assign busy         = busy_q;
   assign refill_valid = valid_q;
   assign refill_err   = err_q;
   assign refill_tag   = tag_q;
   assign mem_req      = mem_req_q;
   assign mem_addr     = mem_addr_q;
   assign d0           = word_q[0];
   assign d1           = word_q[1];
   assign d2           = word_q[2];
   assign d3           = word_q[3];

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: a default-timeout instance for refills,
// stray inputs and reset, and a TIMEOUT=4 instance for the abort path.
module tb_cache_refill_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   always #5 clk = ~clk;

   logic        miss_req, busy, refill_valid, refill_err, mem_req, mem_rvalid;
   logic [31:0] miss_addr, d0, d1, d2, d3, mem_addr, mem_rdata;
   logic [25:0] refill_tag;

   logic        t_miss_req, t_busy, t_refill_valid, t_refill_err, t_mem_req, t_mem_rvalid;
   logic [31:0] t_miss_addr, t_d0, t_d1, t_d2, t_d3, t_mem_addr, t_mem_rdata;
   logic [25:0] t_refill_tag;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] mdata [4];
   int          mlat  [4];

   cache_refill_ctrl dut (
      .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_addr(miss_addr),
      .busy(busy), .refill_valid(refill_valid), .refill_err(refill_err),
      .refill_tag(refill_tag), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata)
   );

   cache_refill_ctrl #(.TIMEOUT(4)) dut_to (
      .clk(clk), .rst_n(rst_n), .miss_req(t_miss_req), .miss_addr(t_miss_addr),
      .busy(t_busy), .refill_valid(t_refill_valid), .refill_err(t_refill_err),
      .refill_tag(t_refill_tag), .d0(t_d0), .d1(t_d1), .d2(t_d2), .d3(t_d3),
      .mem_req(t_mem_req), .mem_addr(t_mem_addr), .mem_rvalid(t_mem_rvalid),
      .mem_rdata(t_mem_rdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Raises a miss, acts as memory using mdata/mlat, and checks the whole refill.
   // Returns in the IDLE cycle after the refill_valid strobe.
   task automatic run_refill(input string nm, input logic [31:0] addr, input logic [25:0] exp_tag,
                             input logic [31:0] base, input bit hold, input int exp_first);
      int  b      = 0;
      int  w      = 0;
      int  pulses = 0;
      int  first  = -1;
      bit  done   = 1'b0;
      miss_addr = addr;
      miss_req  = 1'b1;
      tick();
      for (int cyc = 2; cyc <= 80 && !done; cyc++) begin
         if (first != -1 && cyc == first + 1) begin
            check({nm, " valid_after"}, refill_valid, 1'b0);
            check({nm, " busy_after"}, busy, 1'b0);
            check({nm, " err"}, refill_err, 1'b0);
            done = 1'b1;
         end else begin
            if (refill_valid === 1'b1) begin
               pulses++;
               first = cyc;
               if (!hold) miss_req = 1'b0;
            end
            check({nm, " busy"}, busy, 1'b1);
            check({nm, " mem_req"}, mem_req, (b < 4));
            if (mem_req === 1'b1 && b < 4) begin
               check({nm, " mem_addr"}, mem_addr, base + 32'(4 * b));
               if (w == mlat[b]) begin
                  mem_rvalid = 1'b1;
                  mem_rdata  = mdata[b];
                  b++;
                  w = 0;
               end else begin
                  mem_rvalid = 1'b0;
                  mem_rdata  = 32'h5555_5555;
                  w++;
               end
            end else begin
               mem_rvalid = 1'b1;
               mem_rdata  = 32'hDEAD_BEEF;
            end
            tick();
         end
      end
      mem_rvalid = 1'b0;
      check({nm, " pulses"}, 64'(pulses), 64'd1);
      check({nm, " valid_cycle"}, 64'(first), 64'(exp_first));
      check({nm, " tag"}, refill_tag, exp_tag);
      check({nm, " d0"}, d0, mdata[0]);
      check({nm, " d1"}, d1, mdata[1]);
      check({nm, " d2"}, d2, mdata[2]);
      check({nm, " d3"}, d3, mdata[3]);
   endtask

   initial begin
      rst_n        = 1'b0;
      miss_req     = 1'b0;
      miss_addr    = '0;
      mem_rvalid   = 1'b0;
      mem_rdata    = '0;
      t_miss_req   = 1'b0;
      t_miss_addr  = '0;
      t_mem_rvalid = 1'b0;
      t_mem_rdata  = '0;
      #12;
      check("rst busy", busy, 1'b0);
      check("rst valid", refill_valid, 1'b0);
      check("rst err", refill_err, 1'b0);
      check("rst mem_req", mem_req, 1'b0);
      check("rst mem_addr", mem_addr, 32'h0);
      check("rst d0", d0, 32'h0);
      check("rst d3", d3, 32'h0);
      check("rst tag", refill_tag, 26'h0);
      check("rst t_busy", t_busy, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();

      // Zero-wait refill
      mdata = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      mlat  = '{0, 0, 0, 0};
      run_refill("zero_wait", 32'h0000_1234, 26'h48, 32'h0000_1230, 1'b0, 6);

      // Stray mem_rvalid while idle
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0_BAD0;
      tick();
      tick();
      mem_rvalid = 1'b0;
      check("stray busy", busy, 1'b0);
      check("stray mem_req", mem_req, 1'b0);
      check("stray d0", d0, 32'hA0);
      check("stray d2", d2, 32'hA2);
      tick();

      // Variable latency 0,3,1,7
      mdata = '{32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 32'hB000_0004};
      mlat  = '{0, 3, 1, 7};
      run_refill("var_lat", 32'h0000_0ABC, 26'h2A, 32'h0000_0AB0, 1'b0, 17);

      // Top of address space
      mdata = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
      mlat  = '{0, 0, 0, 0};
      run_refill("top_addr", 32'hFFFF_FFF8, 26'h3FF_FFFF, 32'hFFFF_FFF0, 1'b0, 6);

      // Back-to-back: miss_req held through RESP, second line queued from IDLE
      mdata = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003};
      mlat  = '{1, 0, 2, 0};
      run_refill("b2b_first", 32'h0000_5678, 26'h159, 32'h0000_5670, 1'b1, 9);
      mdata = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
      mlat  = '{0, 0, 0, 0};
      run_refill("b2b_second", 32'h0000_9ABC, 26'h26A, 32'h0000_9AB0, 1'b0, 6);

      // Timeout on the TIMEOUT=4 instance: beat 2 never answered
      t_miss_addr = 32'h0000_2004;
      t_miss_req  = 1'b1;
      tick();
      t_mem_rvalid = 1'b1;
      t_mem_rdata  = 32'hC0;
      check("to addr0", t_mem_addr, 32'h0000_2000);
      tick();
      t_mem_rdata = 32'hC1;
      check("to addr1", t_mem_addr, 32'h0000_2004);
      tick();
      t_mem_rvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("to wait mem_req", t_mem_req, 1'b1);
         check("to wait addr", t_mem_addr, 32'h0000_2008);
         check("to wait err", t_refill_err, 1'b0);
         tick();
      end
      check("to drop mem_req", t_mem_req, 1'b0);
      check("to err pulse", t_refill_err, 1'b1);
      check("to no valid", t_refill_valid, 1'b0);
      check("to busy in err", t_busy, 1'b1);
      t_miss_req = 1'b0;
      tick();
      check("to err single", t_refill_err, 1'b0);
      check("to busy idle", t_busy, 1'b0);
      check("to no valid after", t_refill_valid, 1'b0);
      check("to tag", t_refill_tag, 26'h80);
      check("to partial d1", t_d1, 32'hC1);

      // Asynchronous reset during beat 1
      miss_addr = 32'h0000_3000;
      miss_req  = 1'b1;
      tick();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hE0;
      tick();
      mem_rvalid = 1'b0;
      check("mid beat1 addr", mem_addr, 32'h0000_3004);
      check("mid d0 captured", d0, 32'hE0);
      #3;
      rst_n = 1'b0;
      #1;
      check("async mem_req", mem_req, 1'b0);
      check("async busy", busy, 1'b0);
      check("async d0", d0, 32'h0);
      check("async d1", d1, 32'h0);
      check("async mem_addr", mem_addr, 32'h0);
      check("async tag", refill_tag, 26'h0);
      miss_req = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst busy", busy, 1'b0);
      mdata = '{32'hF0, 32'hF1, 32'hF2, 32'hF3};
      mlat  = '{0, 0, 0, 0};
      run_refill("after_rst", 32'h0000_0040, 26'h1, 32'h0000_0040, 1'b0, 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
